f_btb: RTL and testbench
========================

Name: f_btb

Overview:
- Fetch-stage branch target buffer. Produces the predicted next PC that travels with each instruction to decode.
- Decode resolves the real next PC and raises fail_predict on a mismatch; this block is the other end of that loop.
- Decode returns resolved jump/branch outcomes through the update port. The block trains a direct-mapped table of targets with 2-bit saturating counters.
- It also holds the predicted PC in a fetch→decode pipeline register, so decode compares against the value for its own instruction.

Parameters:
- PC_W, 13, word-address PC width (matches imem addressing).
- IDX_W, 6, index bits; table has 2**IDX_W entries.
- TAG_W, PC_W-IDX_W, tag bits stored per entry.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- f_pc  in  PC_W  PC being fetched this cycle.
- f_pc_predicted  out  PC_W  predicted next PC for f_pc (combinational); fetch loads this into the PC.
- f_hit  out  1  f_pc matched a valid entry.
- stall  in  1  hold fetch→decode register.
- flush  in  1  squash the fetch→decode register (misprediction redirect).
- d_pc_predicted  out  PC_W  registered prediction aligned with the decode instruction.
- d_pred_valid  out  1  d_pc_predicted belongs to a live instruction.
- upd_valid  in  1  decode resolved a control instruction this cycle; decode holds it low when it cannot calculate the PC.
- upd_pc  in  PC_W  PC of the resolved instruction.
- upd_target  in  PC_W  jump target computed by decode.
- upd_taken  in  1  branch condition true, or unconditional jump.
- upd_uncond  in  1  jal/jalr.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[PC_W], ctr[2].
  - idx = pc[IDX_W-1:0]; tag = pc[PC_W-1:IDX_W].
- Lookup is combinational, zero latency.
  - f_hit = valid[idx] & tag match.
  - f_pc_predicted = (f_hit & ctr[1]) ? target : f_pc+1.
  - f_pc+1 wraps modulo 2**PC_W (0x1FFF→0x0000).
- Update is written at the rising edge when upd_valid=1 and becomes visible to lookup the next cycle. A same-cycle read of the index being written returns the old contents (unless BTB_BYPASS_EN).
- Update rules:
  - Hit, upd_uncond=1: target←upd_target, ctr←11.
  - Hit, taken: target←upd_target, ctr←sat_inc(ctr).
  - Hit, not taken: ctr←sat_dec(ctr); target unchanged; entry stays valid.
  - Miss, taken: allocate (overwrite any occupant). Set valid←1, tag, target←upd_target, ctr←11 if upd_uncond else 10.
  - Miss, not taken: no change.
- Counter saturates at 00 and 11; no wrap.
- Pipeline register, in priority order:
  - If rst_n=0: d_pc_predicted←0, d_pred_valid←0.
  - Else if flush: d_pred_valid←0; d_pc_predicted holds its value.
  - Else if stall: hold both.
  - Else: d_pc_predicted←f_pc_predicted, d_pred_valid←1.
  - flush overrides stall.
- Reset (sync, active-low): all valid←0, all ctr←01, targets and tags don't-care. Outputs after reset: f_hit=0, f_pc_predicted=f_pc+1, d_pred_valid=0, d_pc_predicted=0.
- An update presented during the reset cycle is dropped. Reset mid-training loses all entries.
- upd_valid is independent of stall and flush. A resolution issued during a stall or flush is still written.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined: when upd_valid=1 and upd_pc==f_pc in the same cycle, lookup uses the post-update entry (new target and counter; hit forced to 1 if the update allocates or keeps the entry).
- Undefined: lookup sees only registered state. A tight loop therefore needs one extra cycle to train.

Decomposition:
- define.vh holds PC_W, the default IDX_W, and the counter encodings (CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11).
- One sub-module: btb_ctr2, the 2-bit saturating next-state logic (inputs ctr, taken, uncond; output next ctr). Instantiated once on the update path.

Test Plan:
- Reset, then f_pc=0x0040 → f_hit=0, f_pc_predicted=0x0041, d_pred_valid=0 in the first cycle after reset.
- upd pc=0x0040, target=0x0100, taken=1, uncond=0; next cycle f_pc=0x0040 → f_hit=1, f_pc_predicted=0x0100.
- Same entry, two not-taken updates (10→01→00) → f_pc_predicted=0x0041; one taken update (→01) still predicts 0x0041; a second (→10) predicts 0x0100.
- Alias: upd pc=0x0080 taken (same idx as 0x0040, different tag) → lookup of 0x0040 misses (f_hit=0) and 0x0080 hits.
- Wrap: f_pc=0x1FFF with miss → f_pc_predicted=0x0000.
- Pipeline: stall=1 holds d_pc_predicted across 3 cycles. flush=1 with stall=1 gives d_pred_valid=0 next cycle. Without BTB_BYPASS_EN, upd and f_pc both 0x0040 in the same cycle gives the old prediction (0x0041); with it, 0x0100.

Source files
------------

// File: rtl/f_btb_pkg.sv
// Shared definitions for the fetch-stage branch target buffer: default widths
// and the 2-bit confidence counter encoding.
package f_btb_pkg;

    localparam int BTB_PC_W  = 13;
    localparam int BTB_IDX_W = 6;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/btb_ctr2.sv
// Next-state logic for the 2-bit saturating branch confidence counter.
// Unconditional jumps jump straight to strongly-taken.
module btb_ctr2
    import f_btb_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    input  logic uncond,
    output ctr_e ctr_next
);

    function automatic ctr_e sat_inc(input ctr_e c);
        case (c)
            CTR_SNT: return CTR_WNT;
            CTR_WNT: return CTR_WT;
            default: return CTR_ST;
        endcase
    endfunction

    function automatic ctr_e sat_dec(input ctr_e c);
        case (c)
            CTR_ST:  return CTR_WT;
            CTR_WT:  return CTR_WNT;
            default: return CTR_SNT;
        endcase
    endfunction

    always_comb begin
        ctr_next = ctr;
        if (uncond)
            ctr_next = CTR_ST;
        else if (taken)
            ctr_next = sat_inc(ctr);
        else
            ctr_next = sat_dec(ctr);
    end

endmodule

// File: rtl/f_btb.sv
// Direct-mapped branch target buffer with fetch->decode prediction register.
// Define BTB_BYPASS_EN to let a same-cycle update be seen by the lookup.
module f_btb
    import f_btb_pkg::*;
#(
    parameter int PC_W  = BTB_PC_W,
    parameter int IDX_W = BTB_IDX_W,
    parameter int TAG_W = PC_W - IDX_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] f_pc,
    output logic [PC_W-1:0] f_pc_predicted,
    output logic            f_hit,
    input  logic            stall,
    input  logic            flush,
    output logic [PC_W-1:0] d_pc_predicted,
    output logic            d_pred_valid,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_uncond
);

    localparam int ENTRIES = 1 << IDX_W;

    logic             valid_q [ENTRIES];
    ctr_e             ctr_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             taken_eff;
    logic             upd_we;
    ctr_e             ctr_cur;
    ctr_e             ctr_new;
    logic [PC_W-1:0]  tgt_new;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             lk_hit;
    ctr_e             lk_ctr;
    logic [PC_W-1:0]  lk_tgt;
    logic [PC_W-1:0]  f_pc_inc;

    // Update path: a miss starts from weakly-not-taken so one increment lands on 10.
    assign u_idx     = upd_pc[IDX_W-1:0];
    assign u_tag     = upd_pc[PC_W-1:IDX_W];
    assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign taken_eff = upd_taken | upd_uncond;
    assign ctr_cur   = u_hit ? ctr_q[u_idx] : CTR_WNT;
    assign upd_we    = rst_n && upd_valid && (u_hit || taken_eff);
    assign tgt_new   = taken_eff ? upd_target : tgt_q[u_idx];

    btb_ctr2 u_ctr2 (
        .ctr      (ctr_cur),
        .taken    (taken_eff),
        .uncond   (upd_uncond),
        .ctr_next (ctr_new)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (upd_we) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= ctr_new;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_we) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= tgt_new;
        end
    end

    // Lookup stage (combinational)
    assign f_idx    = f_pc[IDX_W-1:0];
    assign f_tag    = f_pc[PC_W-1:IDX_W];
    assign f_pc_inc = f_pc + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef BTB_BYPASS_EN
    logic byp;
    assign byp    = upd_we && (upd_pc == f_pc);
    assign lk_hit = byp || (valid_q[f_idx] && (tag_q[f_idx] == f_tag));
    assign lk_ctr = byp ? ctr_new : ctr_q[f_idx];
    assign lk_tgt = byp ? tgt_new : tgt_q[f_idx];
`else
    assign lk_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign lk_ctr = ctr_q[f_idx];
    assign lk_tgt = tgt_q[f_idx];
`endif

    assign f_hit          = lk_hit;
    assign f_pc_predicted = (lk_hit && (lk_ctr == CTR_WT || lk_ctr == CTR_ST)) ? lk_tgt : f_pc_inc;

    // Fetch -> decode stage; flush wins over stall and keeps the stale PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_pc_predicted <= '0;
            d_pred_valid   <= 1'b0;
        end else if (flush) begin
            d_pred_valid   <= 1'b0;
        end else if (!stall) begin
            d_pc_predicted <= f_pc_predicted;
            d_pred_valid   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_f_btb.sv
// Scoreboard bench for f_btb: expectations are queued as each cycle is driven
// and compared on the falling edge.
module tb_f_btb;

    localparam int PC_W = 13;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PC_W-1:0] f_pc = '0;
    logic [PC_W-1:0] f_pc_predicted;
    logic            f_hit;
    logic            stall = 1'b0;
    logic            flush = 1'b0;
    logic [PC_W-1:0] d_pc_predicted;
    logic            d_pred_valid;
    logic            upd_valid = 1'b0;
    logic [PC_W-1:0] upd_pc = '0;
    logic [PC_W-1:0] upd_target = '0;
    logic            upd_taken = 1'b0;
    logic            upd_uncond = 1'b0;

    always #5 clk = ~clk;

    f_btb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .f_pc           (f_pc),
        .f_pc_predicted (f_pc_predicted),
        .f_hit          (f_hit),
        .stall          (stall),
        .flush          (flush),
        .d_pc_predicted (d_pc_predicted),
        .d_pred_valid   (d_pred_valid),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_uncond     (upd_uncond)
    );

    typedef struct {
        string           tag;
        bit              cf;
        logic            ehit;
        logic [PC_W-1:0] epred;
        bit              cd;
        logic            edv;
        logic [PC_W-1:0] edpc;
    } exp_t;

    exp_t exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;

    // Decode-register model
    bit              m_known = 1'b0;
    logic            m_dv;
    logic [PC_W-1:0] m_dpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cf) begin
                chk({e.tag, ".f_hit"}, 32'(f_hit), 32'(e.ehit));
                chk({e.tag, ".f_pred"}, 32'(f_pc_predicted), 32'(e.epred));
            end
            if (e.cd) begin
                chk({e.tag, ".d_valid"}, 32'(d_pred_valid), 32'(e.edv));
                chk({e.tag, ".d_pc"}, 32'(d_pc_predicted), 32'(e.edpc));
            end
        end
    end

    // One cycle: drive inputs after the edge, queue expectations, advance the d model.
    task automatic step(input string tag, input logic rst, input logic [PC_W-1:0] pc,
                        input logic uv, input logic [PC_W-1:0] upc, input logic [PC_W-1:0] utgt,
                        input logic utk, input logic unc, input logic st, input logic fl,
                        input logic ehit, input logic [PC_W-1:0] epred);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; f_pc = pc; stall = st; flush = fl;
        upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = utk; upd_uncond = unc;
        e.tag   = tag;
        e.cf    = rst;
        e.ehit  = ehit;
        e.epred = epred;
        e.cd    = m_known;
        e.edv   = m_dv;
        e.edpc  = m_dpc;
        exp_q.push_back(e);
        if (!rst) begin
            m_known = 1'b1; m_dv = 1'b0; m_dpc = '0;
        end else if (fl) begin
            m_dv = 1'b0;
        end else if (!st) begin
            m_dv = 1'b1; m_dpc = epred;
        end
    endtask

    task automatic look(input string tag, input logic [PC_W-1:0] pc, input logic ehit,
                        input logic [PC_W-1:0] epred);
        step(tag, 1'b1, pc, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, ehit, epred);
    endtask

    // Training happens while fetch looks at 0x1FFF (miss, wraps to 0).
    task automatic train(input string tag, input logic [PC_W-1:0] upc, input logic [PC_W-1:0] utgt,
                         input logic utk, input logic unc);
        step(tag, 1'b1, 13'h1FFF, 1'b1, upc, utgt, utk, unc, 1'b0, 1'b0, 1'b0, 13'h0000);
    endtask

    initial begin
        logic            same_hit;
        logic [PC_W-1:0] same_pred;
`ifdef BTB_BYPASS_EN
        same_hit = 1'b1; same_pred = 13'h0100;
`else
        same_hit = 1'b0; same_pred = 13'h0041;
`endif
        step("reset", 1'b0, 13'h0040, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0041);
        look("post_reset", 13'h0040, 1'b0, 13'h0041);
        step("same_cycle_upd", 1'b1, 13'h0040, 1'b1, 13'h0040, 13'h0100, 1'b1, 1'b0,
             1'b0, 1'b0, same_hit, same_pred);
        look("trained", 13'h0040, 1'b1, 13'h0100);
        train("nt1_wrap", 13'h0040, 13'h0555, 1'b0, 1'b0);
        train("nt2", 13'h0040, 13'h0555, 1'b0, 1'b0);
        look("ctr00", 13'h0040, 1'b1, 13'h0041);
        train("t1", 13'h0040, 13'h0100, 1'b1, 1'b0);
        look("ctr01", 13'h0040, 1'b1, 13'h0041);
        train("t2", 13'h0040, 13'h0100, 1'b1, 1'b0);
        look("ctr10", 13'h0040, 1'b1, 13'h0100);
        train("alias_alloc", 13'h0080, 13'h0200, 1'b1, 1'b0);
        look("alias_miss", 13'h0040, 1'b0, 13'h0041);
        look("alias_hit", 13'h0080, 1'b1, 13'h0200);
        train("uncond", 13'h0080, 13'h0300, 1'b1, 1'b1);
        look("uncond_tgt", 13'h0080, 1'b1, 13'h0300);
        train("sat_hi", 13'h0080, 13'h0300, 1'b1, 1'b0);
        train("sat_dec", 13'h0080, 13'h0777, 1'b0, 1'b0);
        look("sat_hold", 13'h0080, 1'b1, 13'h0300);
        look("pipe_load", 13'h0080, 1'b1, 13'h0300);
        step("stall1", 1'b1, 13'h0010, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0011);
        step("stall2_upd", 1'b1, 13'h0011, 1'b1, 13'h0010, 13'h0005, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 13'h0012);
        step("stall3", 1'b1, 13'h0012, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0013);
        step("flush_stall_upd", 1'b1, 13'h0012, 1'b1, 13'h0020, 13'h0007, 1'b0, 1'b1,
             1'b1, 1'b1, 1'b0, 13'h0013);
        look("post_flush", 13'h0040, 1'b0, 13'h0041);
        look("refill", 13'h0013, 1'b0, 13'h0014);
        look("stall_upd_kept", 13'h0010, 1'b1, 13'h0005);
        look("flush_upd_kept", 13'h0020, 1'b1, 13'h0007);
        step("mid_reset", 1'b0, 13'h0030, 1'b1, 13'h0030, 13'h0009, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 13'h0031);
        look("reset_lost", 13'h0080, 1'b0, 13'h0081);
        look("reset_upd_drop", 13'h0030, 1'b0, 13'h0031);
        look("tail", 13'h0030, 1'b0, 13'h0031);

        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
